// File: rtl/count_serializer_pkg.sv
// Shared definitions for the count serializer: FSM state encoding and line levels.
package count_serializer_pkg;

    // PARITY keeps its encoding even in builds without the parity stage.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SHIFT  = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/count_serializer_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the terminal count.
// Clear forces the count back to zero so every FSM state starts a fresh period.
module count_serializer_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic Clock,
    input  logic ResetN,
    input  logic Clear,
    output logic BitTick
);

    localparam int TW = $clog2(BIT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Terminal count marks the last cycle of the current bit period.
    assign BitTick = (cnt_q == LAST);

    // Next count: restart on clear or at the end of a period, else advance.
    always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (Clear || BitTick) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_serializer.sv
// Serializes a WIDTH-bit count word onto one line, LSB first, framed by a
// start bit (0) and a stop bit (1). Each bit is held BIT_CYCLES clocks.
// Optional even-parity bit before the stop bit: define COUNT_SERIALIZER_PARITY_EN.
module count_serializer
    import count_serializer_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int BIT_CYCLES = 1
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic [WIDTH-1:0] Data,
    input  logic             DataValid,
    output logic             DataReady,
    output logic             SerialOut,
    output logic             Busy,
    output logic             Done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]      bitcnt_q, bitcnt_d;
    logic               tick;
    logic               timer_clear;
`ifdef COUNT_SERIALIZER_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // Restart the bit period on every state change, and hold it at zero while idle.
    assign timer_clear = (state_d != state_q) || (state_q == IDLE);

    count_serializer_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .Clear   (timer_clear),
        .BitTick (tick)
    );

    // Next-state logic: capture on handshake, step through the frame on bit ticks.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
`ifdef COUNT_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (DataValid && DataReady) begin
                    state_d = START;
                    shreg_d = Data;
`ifdef COUNT_SERIALIZER_PARITY_EN
                    parity_d = ^Data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + BW'(1);
                    if (bitcnt_q == LAST_BIT) begin
`ifdef COUNT_SERIALIZER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef COUNT_SERIALIZER_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
`ifdef COUNT_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
`ifdef COUNT_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Line level decoded purely from registered state.
    always_comb begin
        SerialOut = LINE_IDLE;
        case (state_q)
            IDLE:   SerialOut = LINE_IDLE;
            START:  SerialOut = LINE_START;
            SHIFT:  SerialOut = shreg_q[0];
`ifdef COUNT_SERIALIZER_PARITY_EN
            PARITY: SerialOut = parity_q;
`endif
            STOP:   SerialOut = LINE_STOP;
            default: SerialOut = LINE_IDLE;
        endcase
    end

    assign DataReady = (state_q == IDLE);
    assign Busy      = (state_q != IDLE);
    assign Done      = (state_q == STOP) && tick;

endmodule

// File: tb/tb_count_serializer.sv
// Directed bench for count_serializer with a per-cycle expectation scoreboard.
// Three instances cover WIDTH=8/BIT_CYCLES=1, WIDTH=8/BIT_CYCLES=3 and WIDTH=64/BIT_CYCLES=1.
module tb_count_serializer;

    typedef struct packed {
        logic ser;
        logic done;
        logic busy;
        logic ready;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [7:0]  d8,  d8b;
    logic [63:0] d64;
    logic        v8, v8b, v64;
    logic        rdy8, ser8, busy8, done8;
    logic        rdy8b, ser8b, busy8b, done8b;
    logic        rdy64, ser64, busy64, done64;

    int   sel;
    logic obs_ser, obs_done, obs_busy, obs_ready;

    int    n_assert = 0;
    int    n_fail   = 0;
    string phase    = "init";
    exp_t  exp_q[$];

    always #5 clk = ~clk;

    count_serializer #(.WIDTH(8), .BIT_CYCLES(1)) dut8 (
        .Clock(clk), .ResetN(rst_n), .Data(d8), .DataValid(v8),
        .DataReady(rdy8), .SerialOut(ser8), .Busy(busy8), .Done(done8));

    count_serializer #(.WIDTH(8), .BIT_CYCLES(3)) dut8b (
        .Clock(clk), .ResetN(rst_n), .Data(d8b), .DataValid(v8b),
        .DataReady(rdy8b), .SerialOut(ser8b), .Busy(busy8b), .Done(done8b));

    count_serializer #(.WIDTH(64), .BIT_CYCLES(1)) dut64 (
        .Clock(clk), .ResetN(rst_n), .Data(d64), .DataValid(v64),
        .DataReady(rdy64), .SerialOut(ser64), .Busy(busy64), .Done(done64));

    always_comb begin
        obs_ser = ser8; obs_done = done8; obs_busy = busy8; obs_ready = rdy8;
        if (sel == 1) begin
            obs_ser = ser8b; obs_done = done8b; obs_busy = busy8b; obs_ready = rdy8b;
        end else if (sel == 2) begin
            obs_ser = ser64; obs_done = done64; obs_busy = busy64; obs_ready = rdy64;
        end
    end

    task automatic check(input string name, input logic o, input logic e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %b expected %b", phase, name, o, e);
        end
    endtask

    task automatic check_all(input exp_t e);
        check("SerialOut", obs_ser,   e.ser);
        check("Done",      obs_done,  e.done);
        check("Busy",      obs_busy,  e.busy);
        check("DataReady", obs_ready, e.ready);
    endtask

    // Expected per-cycle outputs of one frame, starting the cycle after the
    // handshake, followed by one idle cycle.
    task automatic push_frame(input logic [63:0] d, input int w, input int bc);
        logic p;
        p = 1'b0;
        for (int c = 0; c < bc; c++) exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        for (int i = 0; i < w; i++) begin
            p = p ^ d[i];
            for (int c = 0; c < bc; c++) exp_q.push_back('{d[i], 1'b0, 1'b1, 1'b0});
        end
`ifdef COUNT_SERIALIZER_PARITY_EN
        for (int c = 0; c < bc; c++) exp_q.push_back('{p, 1'b0, 1'b1, 1'b0});
`endif
        for (int c = 0; c < bc; c++) exp_q.push_back('{1'b1, (c == bc - 1), 1'b1, 1'b0});
        exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic launch(input int s, input logic [63:0] d, input int w, input int bc);
        sel = s;
        case (s)
            0: begin d8  = d[7:0]; v8  = 1'b1; end
            1: begin d8b = d[7:0]; v8b = 1'b1; end
            default: begin d64 = d; v64 = 1'b1; end
        endcase
        push_frame(d, w, bc);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_all(e);
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        sel = 0;
        d8 = '0; d8b = '0; d64 = '0;
        v8 = 1'b0; v8b = 1'b0; v64 = 1'b0;
        repeat (2) @(negedge clk);

        phase = "reset";
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_all('{1'b1, 1'b0, 1'b0, 1'b1});
        end
        @(negedge clk);
        rst_n = 1'b1;

        phase = "t1_a5";
        launch(0, 64'hA5, 8, 1);
        step();
        v8 = 1'b0;
        drain();

        phase = "t2_bc3";
        launch(1, 64'h01, 8, 3);
        step();
        v8b = 1'b0;
        drain();

        phase = "t3_b2b";
        launch(0, 64'hFF, 8, 1);
        push_frame(64'h00, 8, 1);
        step();
        d8 = 8'h00;
        repeat (11) step();
        v8 = 1'b0;
        drain();

        phase = "t4_reset";
        launch(0, 64'hA5, 8, 1);
        step();
        v8 = 1'b0;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_all('{1'b1, 1'b0, 1'b0, 1'b1});
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all('{1'b1, 1'b0, 1'b0, 1'b1});
        repeat (3) exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1});
        drain();
        launch(0, 64'h3C, 8, 1);
        step();
        v8 = 1'b0;
        drain();

        phase = "t5_w64";
        launch(2, 64'd4, 64, 1);
        step();
        v64 = 1'b0;
        drain();

        phase = "t6_a5";
        launch(0, 64'hA5, 8, 1);
        step();
        v8 = 1'b0;
        drain();

        phase = "t6_07";
        launch(0, 64'h07, 8, 1);
        step();
        v8 = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
